cc1200_rx_frame_writer: RTL
===========================

// Module: cc1200_rx_frame_writer
// PURPOSE
//  Downstream of the CC1200 SPI receive path. Consumes per-packet header results and 12-bit pixels.
//   - Header results: rx_add, rx_add_valid, frame_sync, line_sync.
//   - Pixels: rx_data / rx_valid.
//  Writes pixels into a ping-pong frame buffer and flags each completed frame to the video side.
//  Bad or out-of-range packets are rejected; a partial line is never reported as good.
// PARAMETERS
//  PIX_W        12   pixel width
//  PIX_PER_LINE 8    pixels per packet (one packet = one line)
//  LINE_AW      9    line-index bits; valid lines are 0..N_LINES-1
//  N_LINES      480  lines per frame
//  PIX_AW       3    pixel-index bits, clog2(PIX_PER_LINE)
// PORTS
//  clk           in   1        system clock
//  rstn          in   1        async active-low reset
//  rx_header     in   1        high while header bytes are shifted
//  rx_add_valid  in   1        1-cycle strobe: rx_add, frame_sync and line_sync are valid
//  rx_add        in   16       received line address
//  frame_sync    in   1        frame-sync correlation above threshold
//  line_sync     in   1        line-sync correlation above threshold
//  rx_data       in   PIX_W    pixel
//  rx_valid      in   1        pixel strobe
//  out_of_link   in   1        link lost; level
//  mem_we        out  1        buffer write enable
//  mem_addr      out  1+LINE_AW+PIX_AW  {bank, line, pix}
//  mem_wdata     out  PIX_W    pixel
//  frame_ready   out  1        1-cycle pulse: bank frame_bank is complete
//  frame_bank    out  1        bank just completed
//  line_done     out  1        1-cycle pulse: full line written
//  line_err      out  1        1-cycle pulse: packet dropped or truncated
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, wr_bank 0, pix_cnt 0, line 0.
//  FSM:
//   IDLE : rising edge of rx_header -> HDR.
//   HDR  : rx_add_valid -> classify the packet:
//          - neither sync, or rx_add >= N_LINES -> DROP, pulse line_err.
//          - frame_sync (wins if both set):
//              * if any line was written in wr_bank, pulse frame_ready with frame_bank = wr_bank,
//                then toggle wr_bank.
//              * line = rx_add -> PIX.
//          - line_sync only: line = rx_add -> PIX.
//          rx_header falls with no rx_add_valid -> IDLE, pulse line_err.
//   PIX  : each rx_valid writes one pixel at {wr_bank, line, pix_cnt}; pix_cnt++.
//          - pix_cnt reaches PIX_PER_LINE -> pulse line_done -> IDLE.
//          - rising rx_header while pix_cnt < PIX_PER_LINE -> pulse line_err -> HDR (short line).
//   DROP : ignore rx_valid; rising rx_header -> HDR.
//  Write path: registered, 1-cycle latency from rx_valid to mem_we/mem_addr/mem_wdata.
//  Extra rx_valid after PIX_PER_LINE pixels, or rx_valid outside PIX: ignored, no write.
//  out_of_link high: forces IDLE at any state, no line_done, and holds there until it clears.
//   The in-flight line pulses line_err once; wr_bank is unchanged.
//  Same-cycle rx_header rise and last rx_valid: the pixel is written and line_done pulses, then HDR.
//  Async reset mid-line: no partial write completes; mem_we drops immediately.
// CONFIGURATION
//  CC1200_RX_STATS_EN defined:
//   - adds outputs lines_ok[15:0], lines_bad[15:0], frames[15:0].
//   - counters are saturating; they increment with line_done, line_err and frame_ready respectively.
//   - counters clear on reset only.
//  Not defined: these ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  Shared package cc1200_pkg:
//   - rx_state_t enum {IDLE, HDR, PIX, DROP}.
//   - PIX_W, default N_LINES, sync word constants.
//  One sub-module, cc1200_edge_det: registered rise/fall detector, used for rx_header.
//  FSM, counters and write register stay in the top.
// TESTING
//  - Frame sync with rx_add=0, then 8 pixels 0x001..0x008
//      -> 8 writes at addr {0,0,0..7}, then line_done; no frame_ready (first frame).
//  - Line sync with rx_add=5, 8 pixels
//      -> writes at {0,5,0..7}, line_done.
//  - Next frame sync
//      -> frame_ready with frame_bank=0; following writes use bank 1.
//  - rx_add=480 with line_sync
//      -> line_err, no mem_we for that packet's pixels.
//  - 5 pixels, then rx_header rises
//      -> 5 writes, line_err, no line_done, next packet decoded normally.
//  - out_of_link pulse mid-line (after 3 pixels)
//      -> line_err once, FSM IDLE, no further writes until the next header.
//  - STATS_EN build, 3 good lines and 1 bad line
//      -> lines_ok=3, lines_bad=1.

Source files
------------

// File: rtl/cc1200_pkg.sv
// ---------------------------------------------------------------------------
// cc1200_pkg
// Shared definitions for the CC1200 receive path: receive FSM state type,
// pixel width, default frame geometry, sync word constants and a saturating
// counter helper.
// ---------------------------------------------------------------------------
package cc1200_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PIX  = 2'd2,
        DROP = 2'd3
    } rx_state_t;

    localparam int PIX_W       = 12;
    localparam int N_LINES_DEF = 480;

    // Sync words correlated by the upstream SPI receive path.
    localparam logic [15:0] FRAME_SYNC_WORD = 16'hD391;
    localparam logic [15:0] LINE_SYNC_WORD  = 16'h7A0E;

    // 16-bit increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cc1200_rx_frame_writer_if.sv
// ---------------------------------------------------------------------------
// cc1200_rx_frame_writer_if
// Bundles the receive-side inputs (header results and pixels) and the frame
// buffer write port of cc1200_rx_frame_writer.
//   master : drives rx_* / frame_sync / line_sync, observes the mem_* port
//   slave  : the frame writer; consumes rx_*, drives mem_we/mem_addr/mem_wdata
// mem_addr layout is {bank, line[LINE_AW-1:0], pix[PIX_AW-1:0]}.
// ---------------------------------------------------------------------------
interface cc1200_rx_frame_writer_if #(
    parameter int LINE_AW = 9,
    parameter int PIX_AW  = 3
);
    logic                          rx_header;
    logic                          rx_add_valid;
    logic [15:0]                   rx_add;
    logic                          frame_sync;
    logic                          line_sync;
    logic [cc1200_pkg::PIX_W-1:0]  rx_data;
    logic                          rx_valid;

    logic                          mem_we;
    logic [LINE_AW+PIX_AW:0]       mem_addr;
    logic [cc1200_pkg::PIX_W-1:0]  mem_wdata;

    modport master (
        output rx_header, rx_add_valid, rx_add, frame_sync, line_sync,
               rx_data, rx_valid,
        input  mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  rx_header, rx_add_valid, rx_add, frame_sync, line_sync,
               rx_data, rx_valid,
        output mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cc1200_edge_det.sv
// ---------------------------------------------------------------------------
// cc1200_edge_det
// Rise/fall detector built on a registered copy of the input. rise/fall are
// asserted in the same cycle the input changes level.
//   clk, rstn : clock, async active-low reset
//   din       : level to watch
//   rise      : din is 1 now and was 0 last cycle
//   fall      : din is 0 now and was 1 last cycle
// ---------------------------------------------------------------------------
module cc1200_edge_det (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic din_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) din_q <= 1'b0;
        else       din_q <= din;
    end

    assign rise = din & ~din_q;
    assign fall = ~din & din_q;
endmodule

// File: rtl/cc1200_rx_frame_writer.sv
// ---------------------------------------------------------------------------
// cc1200_rx_frame_writer
// Takes per-packet header results and pixels from the CC1200 receive path
// and writes each packet (one line) into a ping-pong frame buffer. A frame
// sync closes the current bank (if anything was written to it) and flips to
// the other one. Bad, out-of-range, truncated or link-lost packets pulse
// line_err and never produce line_done.
//
// Ports:
//   clk, rstn     : clock, async active-low reset
//   out_of_link   : link lost (level); forces IDLE while high
//   bus (slave)   : rx_header, rx_add_valid, rx_add, frame_sync, line_sync,
//                   rx_data, rx_valid in; mem_we, mem_addr, mem_wdata out
//   frame_ready   : 1-cycle pulse, bank frame_bank is complete
//   frame_bank    : bank just completed
//   line_done     : 1-cycle pulse, full line written
//   line_err      : 1-cycle pulse, packet dropped or truncated
//   lines_ok, lines_bad, frames : saturating statistics, present only when
//                   CC1200_RX_STATS_EN is defined
// Every output is registered: writes appear one cycle after rx_valid.
// ---------------------------------------------------------------------------
module cc1200_rx_frame_writer
    import cc1200_pkg::*;
#(
    parameter int PIX_PER_LINE = 8,
    parameter int LINE_AW      = 9,
    parameter int N_LINES      = N_LINES_DEF,
    parameter int PIX_AW       = 3
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       out_of_link,
    cc1200_rx_frame_writer_if.slave    bus,
    output logic                       frame_ready,
    output logic                       frame_bank,
    output logic                       line_done,
    output logic                       line_err
`ifdef CC1200_RX_STATS_EN
    ,
    output logic [15:0]                lines_ok,
    output logic [15:0]                lines_bad,
    output logic [15:0]                frames
`endif
);
    // One extra bit so the counter can represent PIX_PER_LINE itself.
    localparam logic [PIX_AW:0] LAST_PIX = (PIX_AW+1)'(PIX_PER_LINE - 1);

    rx_state_t             state, state_nxt;
    logic                  wr_bank;
    logic                  bank_dirty;
    logic [LINE_AW-1:0]    line;
    logic [PIX_AW:0]       pix_cnt;

    logic                  hdr_rise, hdr_fall;
    logic                  pix_wr, pix_last;
    logic                  load_line, flip_bank;
    logic                  done_nxt, err_nxt, frdy_nxt;

    logic                  mem_we_q;
    logic [LINE_AW+PIX_AW:0] mem_addr_q;
    logic [PIX_W-1:0]      mem_wdata_q;

    cc1200_edge_det u_hdr_edge (
        .clk  (clk),
        .rstn (rstn),
        .din  (bus.rx_header),
        .rise (hdr_rise),
        .fall (hdr_fall)
    );

    // Only PIX accepts pixels, and never while the link is down.
    assign pix_wr   = (state == PIX) && bus.rx_valid && !out_of_link;
    assign pix_last = pix_wr && (pix_cnt == LAST_PIX);

    always_comb begin
        state_nxt = state;
        load_line = 1'b0;
        flip_bank = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        frdy_nxt  = 1'b0;
        if (out_of_link) begin
            state_nxt = IDLE;
            // Only a packet still being assembled is reported; once in
            // IDLE the held link loss is silent.
            err_nxt   = (state == HDR) || (state == PIX);
        end else begin
            unique case (state)
                IDLE: if (hdr_rise) state_nxt = HDR;
                HDR: begin
                    if (bus.rx_add_valid) begin
                        if ((!bus.frame_sync && !bus.line_sync) ||
                            (bus.rx_add >= 16'(N_LINES))) begin
                            state_nxt = DROP;
                            err_nxt   = 1'b1;
                        end else begin
                            state_nxt = PIX;
                            load_line = 1'b1;
                            // An empty bank is not a frame; keep filling it.
                            if (bus.frame_sync && bank_dirty) begin
                                frdy_nxt  = 1'b1;
                                flip_bank = 1'b1;
                            end
                        end
                    end else if (hdr_fall) begin
                        state_nxt = IDLE;
                        err_nxt   = 1'b1;
                    end
                end
                PIX: begin
                    if (pix_last) begin
                        done_nxt  = 1'b1;
                        // A header starting on the last pixel is not lost.
                        state_nxt = hdr_rise ? HDR : IDLE;
                    end else if (hdr_rise) begin
                        err_nxt   = 1'b1;
                        state_nxt = HDR;
                    end
                end
                DROP: if (hdr_rise) state_nxt = HDR;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            wr_bank    <= 1'b0;
            bank_dirty <= 1'b0;
            line       <= '0;
            pix_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (load_line) begin
                line    <= bus.rx_add[LINE_AW-1:0];
                pix_cnt <= '0;
            end else if (pix_wr) begin
                pix_cnt <= pix_cnt + 1'b1;
            end
            if (flip_bank) begin
                wr_bank    <= ~wr_bank;
                bank_dirty <= 1'b0;
            end else if (pix_wr) begin
                bank_dirty <= 1'b1;
            end
        end
    end

    // Write register and status pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            line_done   <= 1'b0;
            line_err    <= 1'b0;
            frame_ready <= 1'b0;
            frame_bank  <= 1'b0;
        end else begin
            mem_we_q    <= pix_wr;
            if (pix_wr) begin
                mem_addr_q  <= {wr_bank, line, pix_cnt[PIX_AW-1:0]};
                mem_wdata_q <= bus.rx_data;
            end
            line_done   <= done_nxt;
            line_err    <= err_nxt;
            frame_ready <= frdy_nxt;
            if (frdy_nxt) frame_bank <= wr_bank;
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

`ifdef CC1200_RX_STATS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lines_ok  <= '0;
            lines_bad <= '0;
            frames    <= '0;
        end else begin
            if (line_done)   lines_ok  <= sat_inc16(lines_ok);
            if (line_err)    lines_bad <= sat_inc16(lines_bad);
            if (frame_ready) frames    <= sat_inc16(frames);
        end
    end
`endif

endmodule
